// File: rtl/seq_detect_p.sv
// Parametrised serial sequence detector with overlap control,
// registered match flag and saturating match counter.
module seq_detect_p #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CW      = 8,
  localparam int          SW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          x,
  input  logic          clr,
  output logic [SW-1:0] PS,
  output logic          z,
  output logic          z_q,
  output logic [CW-1:0] match_cnt
);

  function automatic int pbit(input int i);
    logic [N-1:0] sh;
    sh = PATTERN >> i;
    return int'(sh[0]);
  endfunction

  // Longest suffix of (prefix k followed by b) that is a proper pattern prefix.
  function automatic int nxt(input int k, input int b);
    int best;
    int lim;
    int sb;
    bit ok;
    best = 0;
    lim  = (k + 1 < N - 1) ? k + 1 : N - 1;
    for (int j = 1; j <= lim; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) begin
        sb = (k + 1 - j + t < k) ? pbit(N - 1 - (k + 1 - j + t)) : b;
        if (sb != pbit(N - 1 - t)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    if (!OVERLAP && k == N - 1 && b == pbit(0)) best = 0;
    return best;
  endfunction

  logic [SW-1:0] tbl [2*N];

  for (genvar k = 0; k < N; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam logic [SW-1:0] NX = SW'(nxt(k, b));
      assign tbl[2*k+b] = NX;
    end
  end

  logic [SW-1:0] ps_nxt;
  logic          hit;

  assign ps_nxt = tbl[{PS, x}];
  assign hit    = (PS == SW'(N - 1)) && (x == PATTERN[0]);
  assign z      = reset_n & en & hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      PS        <= '0;
      z_q       <= 1'b0;
      match_cnt <= '0;
    end else begin
      z_q <= z;
      if (en) PS <= ps_nxt;
      if (clr)
        match_cnt <= '0;
      else if (z && match_cnt != '1)
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: doc/seq_detect_p.md
# seq_detect_p

Parametrised serial sequence detector: the next generation of the lab's fixed 8-state Mealy detector (`clk`, `x`, `PS`, `z`). The pattern, its length and the overlap mode are parameters, and a serial-enable qualifies each input bit. It adds a registered copy of the match flag and a saturating match counter with synchronous clear. It sits directly on a serial bit stream and feeds downstream control logic or the lab testbench monitor.

## Interface
- `N`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011: N-bit pattern. `PATTERN[N-1]` is the first bit expected on `x`.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = matching restarts from empty after each hit.
- `CW`, 8: width of `match_cnt`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `en`  in  1  bit-valid qualifier; `x` is consumed only on edges where `en=1`.
- `x`  in  1  serial input bit.
- `clr`  in  1  synchronous clear of `match_cnt`.
- `PS`  out  SW=$clog2(N)  present state = number of pattern bits currently matched, 0..N-1.
- `z`  out  1  Mealy match flag (combinational).
- `z_q`  out  1  `z` registered: high for the cycle after a consumed match.
- `match_cnt`  out  CW  saturating count of matches.

## Operation
- State meaning: `PS=k` means the last k consumed bits equal `PATTERN[N-1 -: k]`. The value N is never stored.
- `z = reset_n & en & (PS==N-1) & (x==PATTERN[0])`.
- Next state when `en=1`:
  - Advance: if `x==PATTERN[N-1-PS]` and `PS<N-1`, next `PS = PS+1`.
  - Match: if `PS==N-1` and `x==PATTERN[0]`, then `z=1`.
    - OVERLAP=1: next PS = largest k<N such that the last k bits of PATTERN equal its first k bits (failure value of the full pattern).
    - OVERLAP=0: next PS = 0.
  - Mismatch: next PS = largest k ≤ PS such that the last k bits of (matched prefix followed by `x`) equal `PATTERN[N-1 -: k]`; 0 if none.
  - Transition logic is derived at elaboration from `PATTERN` (generate or constant function). No hand-written per-pattern tables.
- `en=0`:
  - PS holds.
  - `z=0`.
  - No count update.
- `match_cnt`:
  - +1 on each edge with `z=1`.
  - Saturates at 2^CW-1 and does not wrap.
  - `clr=1` forces 0; clr wins over a simultaneous match (result 0, not 1).
- Reset (`reset_n=0` at an edge):
  - `PS=0`, `z_q=0`, `match_cnt=0`.
  - `z` is 0 combinationally while `reset_n=0`.
  - Reset mid-pattern discards partial progress. The first bit after release is treated as the first bit of a new stream.

## Timing
- `z` is valid in the same cycle the final pattern bit is presented on `x`. The bench samples `x`/`z` just before the rising edge.
- `PS`, `z_q` and `match_cnt` reflect a consumed bit one edge later.
- No pipeline stall or backpressure: one bit per enabled cycle, sustained.
- Bit interval is arbitrary: any number of `en=0` cycles between bits leaves detection unaffected.

## Test plan
- Default params (1011, OVERLAP=1), reset then `en=1`, stream 1,0,1,1,0,1,1:
  - `z=1` exactly on the 4th and 7th bits.
  - `PS` after each edge: 1,2,3,1,2,3,1.
  - `match_cnt=2`.
- Same stream with OVERLAP=0:
  - `z=1` only on the 4th bit.
  - `PS` after the 4th..7th edges: 0,0,1,1.
  - `match_cnt=1`.
- Mismatch fallback, PATTERN=4'b1101, OVERLAP=1, stream 1,1,1,0,1:
  - `PS` after each edge: 1,2,2,3,1.
  - `z=1` on the 5th bit.
- Enable gaps: insert 3 `en=0` cycles between every bit of 1,0,1,1 with `x` toggling randomly during the gaps.
  - `PS` holds during every gap.
  - `z` fires once, on the final enabled bit.
- Reset at PS=3 (bits 1,0,1 sent, then `reset_n=0` for one edge), then 1,0,1,1:
  - `PS=0` and `match_cnt` cleared at the reset edge.
  - Exactly one match, at the final bit.
- Counter, CW=2, continuous overlapping stream of 1011 repeats:
  - `match_cnt` goes 1,2,3,3 (saturates).
  - `clr` asserted on a match edge leaves `match_cnt=0`.
  - `z_q` pulses one cycle after each `z`.
